// File: rtl/frog_countdown.sv
// frog_countdown: BCD round timer for the frog game.
// Counts a two-digit BCD seconds value down from START_SEC, one step per
// rising edge of the divided 1 Hz square wave, and flags timeout.
module frog_countdown #(
    parameter int START_SEC = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start,
    input  logic       pause,
    input  logic       reload,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       time_up,
    output logic       timeout_pulse
);

    localparam logic [3:0] START_TENS = 4'(START_SEC / 10);
    localparam logic [3:0] START_ONES = 4'(START_SEC % 10);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_TIMEUP
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       s1;
    logic       s2;
    logic       s3;
    logic       sec_tick;
    logic [3:0] tens_next;
    logic [3:0] ones_next;
    logic       pulse_next;

    // One-step BCD decrement with borrow from tens into ones.
    function automatic logic [7:0] bcd_dec(input logic [3:0] tens, input logic [3:0] ones);
        if (ones != 4'd0) begin
            return {tens, ones - 4'd1};
        end
        return {tens - 4'd1, 4'd9};
    endfunction

    // Rising edge of the synchronized tick; falling edges are ignored.
    assign sec_tick = s2 & ~s3;

    // Two-flop synchronizer for tick_in plus a history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tick_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Next state and next digits; reload > pause > start > sec_tick.
    always_comb begin
        state_next = state;
        tens_next  = sec_tens;
        ones_next  = sec_ones;
        pulse_next = 1'b0;
        if (reload) begin
            state_next = ST_IDLE;
            tens_next  = START_TENS;
            ones_next  = START_ONES;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!pause && start) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        // A tick arriving together with pause is dropped.
                        state_next = ST_PAUSE;
                    end else if (sec_tick) begin
                        // 01 (or an already-empty 00) ends the round; never go below 00.
                        if (sec_tens == 4'd0 && sec_ones <= 4'd1) begin
                            tens_next  = 4'd0;
                            ones_next  = 4'd0;
                            state_next = ST_TIMEUP;
                            pulse_next = 1'b1;
                        end else begin
                            {tens_next, ones_next} = bcd_dec(sec_tens, sec_ones);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause && start) begin
                        state_next = ST_RUN;
                    end
                end
                ST_TIMEUP: begin
                    tens_next = 4'd0;
                    ones_next = 4'd0;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State, digit and flag registers; flags are decoded from the next state so outputs stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            sec_tens      <= START_TENS;
            sec_ones      <= START_ONES;
            running       <= 1'b0;
            time_up       <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            sec_tens      <= tens_next;
            sec_ones      <= ones_next;
            running       <= (state_next == ST_RUN);
            time_up       <= (state_next == ST_TIMEUP);
            timeout_pulse <= pulse_next;
        end
    end

endmodule

// File: tb/tb_frog_countdown.sv
// Bench for frog_countdown: scoreboard of expected digit changes plus
// per-scenario flag/digit checks on a START_SEC=3 and a START_SEC=10 instance.
module tb_frog_countdown;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_in, start, pause, reload;
    logic [3:0] sec_tens, sec_ones;
    logic       running, time_up, timeout_pulse;

    logic       tick10, start10, pause10, reload10;
    logic [3:0] tens10, ones10;
    logic       running10, time_up10, pulse10;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] digits;
        int         due;
    } exp_t;

    exp_t       sb[$];
    bit         mon_en = 1'b0;
    logic [7:0] prev_digits;
    logic [10:0] obs;

    frog_countdown #(.START_SEC(3)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .pause(pause),
        .reload(reload), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .time_up(time_up), .timeout_pulse(timeout_pulse)
    );

    frog_countdown #(.START_SEC(10)) dut10 (
        .clk(clk), .rst(rst), .tick_in(tick10), .start(start10), .pause(pause10),
        .reload(reload10), .sec_tens(tens10), .sec_ones(ones10),
        .running(running10), .time_up(time_up10), .timeout_pulse(pulse10)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign obs = {sec_tens, sec_ones, running, time_up, timeout_pulse};

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [10:0] mk(input int v, input bit r, input bit t, input bit p);
        return {bcd(v), r, t, p};
    endfunction

    // Scoreboard: every change of the displayed digits must match the oldest expectation, in value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && {sec_tens, sec_ones} !== prev_digits) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: digits became %h at cycle %0d, required %h unchanged",
                         {sec_tens, sec_ones}, cyc, prev_digits);
            end else begin
                e = sb.pop_front();
                if ({sec_tens, sec_ones} !== e.digits || cyc != e.due) begin
                    n_err++;
                    $display("FAIL sb_digits: got %h at cycle %0d, required %h at cycle %0d",
                             {sec_tens, sec_ones}, cyc, e.digits, e.due);
                end
            end
            prev_digits = {sec_tens, sec_ones};
        end
    end

    // Ticks are driven at a negedge: sampled at the next posedge (edge k), digits move at edge k+2.
    task automatic tick_pulse(input bit expect_dec, input int new_val);
        exp_t e;
        if (expect_dec) begin
            e.digits = bcd(new_val);
            e.due    = cyc + 3;
            sb.push_back(e);
        end
        tick_in = 1'b1;
        repeat (3) @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic push_now(input int v);
        exp_t e;
        if ({sec_tens, sec_ones} !== bcd(v)) begin
            e.digits = bcd(v);
            e.due    = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick_in = 1'b0; start = 1'b0; pause = 1'b0; reload = 1'b0;
        tick10 = 1'b0; start10 = 1'b0; pause10 = 1'b0; reload10 = 1'b0;
        repeat (2) @(negedge clk);
        tick_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs !== mk(3, 0, 0, 0)) begin
            n_err++; $display("FAIL reset_state: got %h, required %h", obs, mk(3, 0, 0, 0));
        end
        n_cmp++;
        if ({tens10, ones10, running10, time_up10, pulse10} !== mk(10, 0, 0, 0)) begin
            n_err++; $display("FAIL reset_state10: got %h, required %h",
                              {tens10, ones10, running10, time_up10, pulse10}, mk(10, 0, 0, 0));
        end
        prev_digits = 8'h03;
        mon_en = 1'b1;
        tick_in = 1'b0;
        repeat (2) @(negedge clk);
        pause = 1'b1;
        tick_pulse(0, 0);
        pause = 1'b0;
        repeat (3) tick_pulse(0, 0);
        n_cmp++;
        if (obs !== mk(3, 0, 0, 0)) begin
            n_err++; $display("FAIL idle_ignores_ticks: got %h, required %h", obs, mk(3, 0, 0, 0));
        end
    endtask

    task automatic test_countdown();
        exp_t e;
        pulse_start();
        n_cmp++;
        if (obs !== mk(3, 1, 0, 0)) begin
            n_err++; $display("FAIL start_run: got %h, required %h", obs, mk(3, 1, 0, 0));
        end
        tick_pulse(1, 2);
        tick_pulse(1, 1);
        n_cmp++;
        if (obs !== mk(1, 1, 0, 0)) begin
            n_err++; $display("FAIL count_01: got %h, required %h", obs, mk(1, 1, 0, 0));
        end
        e.digits = 8'h00;
        e.due    = cyc + 3;
        sb.push_back(e);
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs !== mk(1, 1, 0, 0)) begin
            n_err++; $display("FAIL tick_latency: got %h, required %h", obs, mk(1, 1, 0, 0));
        end
        @(negedge clk);
        n_cmp++;
        if (obs !== mk(0, 0, 1, 1)) begin
            n_err++; $display("FAIL timeout_entry: got %h, required %h", obs, mk(0, 0, 1, 1));
        end
        @(negedge clk);
        n_cmp++;
        if (obs !== mk(0, 0, 1, 0)) begin
            n_err++; $display("FAIL timeout_one_cycle: got %h, required %h", obs, mk(0, 0, 1, 0));
        end
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeup_hold();
        start = 1'b1; pause = 1'b1;
        @(negedge clk);
        start = 1'b0; pause = 1'b0;
        pulse_start();
        tick_pulse(0, 0);
        tick_pulse(0, 0);
        n_cmp++;
        if (obs !== mk(0, 0, 1, 0)) begin
            n_err++; $display("FAIL timeup_hold: got %h, required %h", obs, mk(0, 0, 1, 0));
        end
        push_now(3);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        n_cmp++;
        if (obs !== mk(3, 0, 0, 0)) begin
            n_err++; $display("FAIL reload_idle: got %h, required %h", obs, mk(3, 0, 0, 0));
        end
    endtask

    task automatic test_pause();
        pulse_start();
        tick_pulse(1, 2);
        pause = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== mk(2, 0, 0, 0)) begin
            n_err++; $display("FAIL pause_enter: got %h, required %h", obs, mk(2, 0, 0, 0));
        end
        repeat (5) tick_pulse(0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (obs !== mk(2, 0, 0, 0)) begin
            n_err++; $display("FAIL pause_over_start: got %h, required %h", obs, mk(2, 0, 0, 0));
        end
        pause = 1'b0;
        pulse_start();
        n_cmp++;
        if (obs !== mk(2, 1, 0, 0)) begin
            n_err++; $display("FAIL resume: got %h, required %h", obs, mk(2, 1, 0, 0));
        end
        // Line pause up with the single cycle in which sec_tick is high.
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        n_cmp++;
        if (obs !== mk(2, 0, 0, 0)) begin
            n_err++; $display("FAIL pause_drops_tick: got %h, required %h", obs, mk(2, 0, 0, 0));
        end
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        pulse_start();
        tick_pulse(1, 1);
        n_cmp++;
        if (obs !== mk(1, 1, 0, 0)) begin
            n_err++; $display("FAIL resume_tick: got %h, required %h", obs, mk(1, 1, 0, 0));
        end
    endtask

    task automatic test_reset_midcount();
        push_now(3);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        pulse_start();
        tick_pulse(1, 2);
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        push_now(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (obs !== mk(3, 0, 0, 0)) begin
            n_err++; $display("FAIL reset_midcount: got %h, required %h", obs, mk(3, 0, 0, 0));
        end
        repeat (3) @(negedge clk);
        tick_in = 1'b0;
        n_cmp++;
        if (obs !== mk(3, 0, 0, 0)) begin
            n_err++; $display("FAIL reset_no_decrement: got %h, required %h", obs, mk(3, 0, 0, 0));
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bcd_borrow();
        start10 = 1'b1;
        @(negedge clk);
        start10 = 1'b0;
        n_cmp++;
        if ({tens10, ones10, running10} !== {bcd(10), 1'b1}) begin
            n_err++; $display("FAIL start10: got %h, required %h", {tens10, ones10, running10}, {bcd(10), 1'b1});
        end
        for (int i = 9; i >= 8; i--) begin
            tick10 = 1'b1;
            repeat (3) @(negedge clk);
            tick10 = 1'b0;
            n_cmp++;
            if ({tens10, ones10, running10, time_up10} !== {bcd(i), 2'b10}) begin
                n_err++; $display("FAIL bcd_borrow_%0d: got %h, required %h",
                                  i, {tens10, ones10, running10, time_up10}, {bcd(i), 2'b10});
            end
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_countdown();
        test_timeup_hold();
        test_pause();
        test_reset_midcount();
        test_bcd_borrow();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
